// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of one memory port between I-cache refill and D-cache, with a hung-access watchdog
module mem_bus_arbiter #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ICACHE_REQ_SI,
    input  logic [31:0] ICACHE_ADR_SI,
    output logic        ICACHE_ACK_SA,
    output logic [31:0] ICACHE_RDATA_SA,
    output logic        ICACHE_ERR_SA,
    input  logic        DCACHE_REQ_SD,
    input  logic [31:0] DCACHE_ADR_SD,
    input  logic [31:0] DCACHE_WDATA_SD,
    input  logic        DCACHE_STORE_SD,
    input  logic [3:0]  DCACHE_BYT_SEL_SD,
    output logic        DCACHE_ACK_SA,
    output logic [31:0] DCACHE_RDATA_SA,
    output logic        DCACHE_ERR_SA,
    output logic        RAM_REQ_SA,
    output logic [31:0] RAM_ADR_SA,
    output logic [31:0] RAM_WDATA_SA,
    output logic        RAM_STORE_SA,
    output logic [3:0]  RAM_BYT_SEL_SA,
    input  logic        RAM_ACK_SR,
    input  logic [31:0] RAM_RDATA_SR,
    input  logic        RAM_ERR_SR,
    output logic        BUSY_SA
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t        r_state, w_next;
    logic          r_last_d, r_store, r_err;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_adr, r_wdata, r_rdata;
    logic [3:0]    r_bsel;
    logic          w_req, w_pick_d, w_timeout;

    assign w_req     = ICACHE_REQ_SI | DCACHE_REQ_SD;
    assign w_pick_d  = DCACHE_REQ_SD & (~ICACHE_REQ_SI | ~r_last_d);
    assign w_timeout = r_cnt == CW'(TIMEOUT - 1);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next state: grant from IDLE, leave BUSY on ack, error or watchdog expiry, RESP lasts one cycle
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_next = w_req ? S_BUSY : S_IDLE;
            S_BUSY:  w_next = (RAM_ACK_SR | RAM_ERR_SR | w_timeout) ? S_RESP : S_BUSY;
            default: w_next = S_IDLE;
        endcase
    end

    // Grant bookkeeping, payload latch, watchdog count and response capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_d <= 1'b0;
            r_adr    <= '0;
            r_wdata  <= '0;
            r_store  <= 1'b0;
            r_bsel   <= '0;
            r_cnt    <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else if (r_state == S_IDLE && w_req) begin
            r_last_d <= w_pick_d;
            r_adr    <= w_pick_d ? DCACHE_ADR_SD : ICACHE_ADR_SI;
            r_wdata  <= w_pick_d ? DCACHE_WDATA_SD : '0;
            r_store  <= w_pick_d & DCACHE_STORE_SD;
            r_bsel   <= w_pick_d ? DCACHE_BYT_SEL_SD : 4'b1111;
            r_cnt    <= '0;
        end else if (r_state == S_BUSY) begin
            if (RAM_ACK_SR) begin
                r_rdata <= r_store ? '0 : RAM_RDATA_SR;
                r_err   <= 1'b0;
            end else if (RAM_ERR_SR | w_timeout) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

    // Decode the registered state and payload onto the ports; idle/unselected outputs read as 0
    always_comb begin
        BUSY_SA         = r_state != S_IDLE;
        RAM_REQ_SA      = r_state == S_BUSY;
        RAM_ADR_SA      = RAM_REQ_SA ? r_adr : '0;
        RAM_WDATA_SA    = RAM_REQ_SA ? r_wdata : '0;
        RAM_STORE_SA    = RAM_REQ_SA & r_store;
        RAM_BYT_SEL_SA  = RAM_REQ_SA ? r_bsel : '0;
        ICACHE_ACK_SA   = r_state == S_RESP && !r_last_d;
        ICACHE_RDATA_SA = ICACHE_ACK_SA ? r_rdata : '0;
        ICACHE_ERR_SA   = ICACHE_ACK_SA & r_err;
        DCACHE_ACK_SA   = r_state == S_RESP && r_last_d;
        DCACHE_RDATA_SA = DCACHE_ACK_SA ? r_rdata : '0;
        DCACHE_ERR_SA   = DCACHE_ACK_SA & r_err;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized checks of mem_bus_arbiter against a transaction-level model
module tb_mem_bus_arbiter;
    localparam int TMO = 8;

    logic        clk = 0, reset_n = 0;
    logic        ICACHE_REQ_SI = 0;
    logic [31:0] ICACHE_ADR_SI = 0;
    logic        ICACHE_ACK_SA, ICACHE_ERR_SA;
    logic [31:0] ICACHE_RDATA_SA;
    logic        DCACHE_REQ_SD = 0, DCACHE_STORE_SD = 0;
    logic [31:0] DCACHE_ADR_SD = 0, DCACHE_WDATA_SD = 0;
    logic [3:0]  DCACHE_BYT_SEL_SD = 0;
    logic        DCACHE_ACK_SA, DCACHE_ERR_SA;
    logic [31:0] DCACHE_RDATA_SA;
    logic        RAM_REQ_SA, RAM_STORE_SA, BUSY_SA;
    logic [31:0] RAM_ADR_SA, RAM_WDATA_SA;
    logic [3:0]  RAM_BYT_SEL_SA;
    logic        RAM_ACK_SR = 0, RAM_ERR_SR = 0;
    logic [31:0] RAM_RDATA_SR = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .ICACHE_REQ_SI(ICACHE_REQ_SI), .ICACHE_ADR_SI(ICACHE_ADR_SI),
        .ICACHE_ACK_SA(ICACHE_ACK_SA), .ICACHE_RDATA_SA(ICACHE_RDATA_SA), .ICACHE_ERR_SA(ICACHE_ERR_SA),
        .DCACHE_REQ_SD(DCACHE_REQ_SD), .DCACHE_ADR_SD(DCACHE_ADR_SD), .DCACHE_WDATA_SD(DCACHE_WDATA_SD),
        .DCACHE_STORE_SD(DCACHE_STORE_SD), .DCACHE_BYT_SEL_SD(DCACHE_BYT_SEL_SD),
        .DCACHE_ACK_SA(DCACHE_ACK_SA), .DCACHE_RDATA_SA(DCACHE_RDATA_SA), .DCACHE_ERR_SA(DCACHE_ERR_SA),
        .RAM_REQ_SA(RAM_REQ_SA), .RAM_ADR_SA(RAM_ADR_SA), .RAM_WDATA_SA(RAM_WDATA_SA),
        .RAM_STORE_SA(RAM_STORE_SA), .RAM_BYT_SEL_SA(RAM_BYT_SEL_SA),
        .RAM_ACK_SR(RAM_ACK_SR), .RAM_RDATA_SR(RAM_RDATA_SR), .RAM_ERR_SR(RAM_ERR_SR),
        .BUSY_SA(BUSY_SA)
    );

    int          errors = 0, checks = 0;
    bit          i_pend, d_pend, cont, rand_req, rand_mem;
    int          bcnt, ack_at, err_at;
    logic [31:0] mem_rdata = 0;
    bit          gq[$];

    // Reference: one outstanding transaction record; the served side is remembered for fairness
    bit          m_busy, m_resp, m_d, m_last_d, m_st, m_err;
    int          m_age;
    logic [31:0] m_adr = 0, m_wd = 0, m_rd = 0;
    logic [3:0]  m_bs = 0;
    wire         want_d = DCACHE_REQ_SD && !(ICACHE_REQ_SI && m_last_d);

    // Advance the reference one clock using the inputs the DUT samples at the same edge
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 0; m_resp <= 0; m_d <= 0; m_last_d <= 0; m_age <= 0;
        end else if (m_resp) begin
            m_resp <= 0;
        end else if (m_busy) begin
            if (RAM_ACK_SR || RAM_ERR_SR || m_age + 1 == TMO) begin
                m_busy <= 0;
                m_resp <= 1;
                m_err  <= !RAM_ACK_SR;
                m_rd   <= (RAM_ACK_SR && !m_st) ? RAM_RDATA_SR : 32'h0;
            end else begin
                m_age <= m_age + 1;
            end
        end else if (ICACHE_REQ_SI || DCACHE_REQ_SD) begin
            m_busy   <= 1;
            m_age    <= 0;
            m_d      <= want_d;
            m_last_d <= want_d;
            m_adr    <= want_d ? DCACHE_ADR_SD : ICACHE_ADR_SI;
            m_wd     <= want_d ? DCACHE_WDATA_SD : 32'h0;
            m_st     <= want_d && DCACHE_STORE_SD;
            m_bs     <= want_d ? DCACHE_BYT_SEL_SD : 4'hF;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic req_i(input logic [31:0] a);
        ICACHE_REQ_SI = 1; ICACHE_ADR_SI = a; i_pend = 1;
    endtask

    task automatic req_d(input logic [31:0] a, input logic [31:0] wd, input bit st, input logic [3:0] bs);
        DCACHE_REQ_SD = 1; DCACHE_ADR_SD = a; DCACHE_WDATA_SD = wd;
        DCACHE_STORE_SD = st; DCACHE_BYT_SEL_SD = bs; d_pend = 1;
    endtask

    // One clock: compare DUT against the reference mid-cycle, then drive requesters and memory for the next cycle
    task automatic step();
        bit ai, ad, ie, de;
        ai = ICACHE_ACK_SA; ad = DCACHE_ACK_SA;
        @(negedge clk);
        ie = m_resp && !m_d;
        de = m_resp && m_d;
        chk("busy", BUSY_SA, m_busy || m_resp);
        chk("ram_req", RAM_REQ_SA, m_busy);
        chk("ram_adr", RAM_ADR_SA, m_busy ? m_adr : 32'h0);
        chk("ram_wdata", RAM_WDATA_SA, m_busy ? m_wd : 32'h0);
        chk("ram_store", RAM_STORE_SA, m_busy && m_st);
        chk("ram_bsel", RAM_BYT_SEL_SA, m_busy ? m_bs : 4'h0);
        chk("i_ack", ICACHE_ACK_SA, ie);
        chk("i_rdata", ICACHE_RDATA_SA, ie ? m_rd : 32'h0);
        chk("i_err", ICACHE_ERR_SA, ie && m_err);
        chk("d_ack", DCACHE_ACK_SA, de);
        chk("d_rdata", DCACHE_RDATA_SA, de ? m_rd : 32'h0);
        chk("d_err", DCACHE_ERR_SA, de && m_err);
        if (DCACHE_ACK_SA) gq.push_back(1);
        if (ICACHE_ACK_SA) gq.push_back(0);
        @(posedge clk);
        #1;
        if (ai) begin
            ICACHE_REQ_SI = 0; i_pend = 0;
        end else if (!i_pend && (cont || (rand_req && $urandom_range(0, 2) == 0))) begin
            req_i($urandom);
        end
        if (ad) begin
            DCACHE_REQ_SD = 0; d_pend = 0;
        end else if (!d_pend && (cont || (rand_req && $urandom_range(0, 2) == 0))) begin
            req_d($urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom));
        end
        if (RAM_REQ_SA) begin
            if (bcnt == 0 && rand_mem) begin
                ack_at = $urandom_range(1, 10);
                err_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 0;
            end
            bcnt++;
            RAM_ACK_SR   = bcnt == ack_at;
            RAM_ERR_SR   = bcnt == err_at;
            RAM_RDATA_SR = rand_mem ? $urandom : mem_rdata;
        end else begin
            bcnt = 0;
            RAM_ACK_SR   = rand_mem && $urandom_range(0, 1) == 1;
            RAM_ERR_SR   = rand_mem && $urandom_range(0, 1) == 1;
            RAM_RDATA_SR = $urandom;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (i_pend || d_pend || BUSY_SA); k++) step();
        chk("drain_idle", {i_pend, d_pend, BUSY_SA}, 0);
    endtask

    task automatic wait_ack(input bit d);
        for (int k = 0; k < 40 && !(d ? DCACHE_ACK_SA : ICACHE_ACK_SA); k++) step();
        chk("ack_seen", d ? DCACHE_ACK_SA : ICACHE_ACK_SA, 1);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", BUSY_SA, 0);
        chk("rst_ram_req", RAM_REQ_SA, 0);
        chk("rst_ram_adr", RAM_ADR_SA, 0);
        chk("rst_i_ack", ICACHE_ACK_SA, 0);
        chk("rst_d_ack", DCACHE_ACK_SA, 0);
        reset_n = 1;

        ack_at = 1; err_at = 0; mem_rdata = 32'h11111111;
        gq.delete();
        cont = 1;
        req_i(32'h1000);
        req_d(32'h2000, 0, 0, 4'hF);
        repeat (24) step();
        cont = 0;
        drain();
        chk("order_len", gq.size() >= 4, 1);
        chk("order0_d", gq[0], 1);
        chk("order1_i", gq[1], 0);
        chk("order2_d", gq[2], 1);
        chk("order3_i", gq[3], 0);

        ack_at = 1; mem_rdata = 32'hDEADBEEF;
        req_d(32'h100, 0, 0, 4'b1111);
        step();
        chk("t1_ram_req", RAM_REQ_SA, 1);
        chk("t1_ram_adr", RAM_ADR_SA, 32'h100);
        chk("t1_ram_bsel", RAM_BYT_SEL_SA, 4'b1111);
        step();
        chk("t1_d_ack", DCACHE_ACK_SA, 1);
        chk("t1_d_rdata", DCACHE_RDATA_SA, 32'hDEADBEEF);
        chk("t1_d_err", DCACHE_ERR_SA, 0);
        chk("t1_i_ack", ICACHE_ACK_SA, 0);
        drain();

        ack_at = 4; mem_rdata = 32'h12345678;
        req_d(32'h700, 32'h00AB0000, 1, 4'b0100);
        step();
        chk("t3_wdata", RAM_WDATA_SA, 32'h00AB0000);
        chk("t3_bsel", RAM_BYT_SEL_SA, 4'b0100);
        n = RAM_STORE_SA;
        for (int k = 0; k < 20 && !DCACHE_ACK_SA; k++) begin
            step();
            n += RAM_STORE_SA;
        end
        chk("t3_store_cycles", n, 4);
        chk("t3_d_ack", DCACHE_ACK_SA, 1);
        chk("t3_d_rdata", DCACHE_RDATA_SA, 0);
        chk("t3_d_err", DCACHE_ERR_SA, 0);
        drain();

        ack_at = 0; err_at = 0;
        req_i(32'h2000);
        step();
        n = 0;
        for (int k = 0; k < 40 && RAM_REQ_SA; k++) begin
            n++;
            step();
        end
        chk("t4_req_cycles", n, TMO);
        chk("t4_i_ack", ICACHE_ACK_SA, 1);
        chk("t4_i_err", ICACHE_ERR_SA, 1);
        chk("t4_i_rdata", ICACHE_RDATA_SA, 0);
        chk("t4_busy_resp", BUSY_SA, 1);
        step();
        chk("t4_busy_after", BUSY_SA, 0);
        drain();

        ack_at = 2; err_at = 2; mem_rdata = 32'hCAFE0001;
        req_d(32'h300, 0, 0, 4'hF);
        wait_ack(1);
        chk("t5_both_err", DCACHE_ERR_SA, 0);
        chk("t5_both_rdata", DCACHE_RDATA_SA, 32'hCAFE0001);
        drain();
        ack_at = 0; err_at = 2;
        req_d(32'h304, 0, 0, 4'hF);
        wait_ack(1);
        chk("t5_err_err", DCACHE_ERR_SA, 1);
        chk("t5_err_rdata", DCACHE_RDATA_SA, 0);
        drain();

        ack_at = 0; err_at = 0;
        req_d(32'h5000, 32'h55, 1, 4'h3);
        req_i(32'h6000);
        repeat (3) step();
        chk("t6_busy_before", RAM_REQ_SA, 1);
        #2 reset_n = 0;
        #1;
        chk("t6_rst_busy", BUSY_SA, 0);
        chk("t6_rst_ram_req", RAM_REQ_SA, 0);
        chk("t6_rst_ram_adr", RAM_ADR_SA, 0);
        chk("t6_rst_store", RAM_STORE_SA, 0);
        chk("t6_rst_d_ack", DCACHE_ACK_SA, 0);
        chk("t6_rst_i_ack", ICACHE_ACK_SA, 0);
        ICACHE_REQ_SI = 0; DCACHE_REQ_SD = 0; i_pend = 0; d_pend = 0;
        step();
        step();
        reset_n = 1;
        ack_at = 1;
        req_i(32'h6100);
        req_d(32'h5100, 0, 0, 4'hF);
        step();
        chk("t6_regrant_req", RAM_REQ_SA, 1);
        chk("t6_regrant_d", RAM_ADR_SA, 32'h5100);
        drain();

        rand_mem = 1;
        rand_req = 1;
        repeat (3000) step();
        rand_req = 0;
        drain();
        rand_mem = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
